// File: rtl/ft6206_defines.sv
// FT6206 touch controller constants and controller state encoding.
`ifndef FT6206_ADDRESS
`define FT6206_ADDRESS 7'h38
`endif

package ft6206_defines;

   localparam logic [7:0] FT6206_REG_TD_STATUS = 8'h02;
   localparam logic [7:0] FT6206_REG_TH_GROUP  = 8'h80;

   typedef enum logic [2:0] {
      S_INIT,
      S_INIT_WAIT,
      S_IDLE,
      S_PTR,
      S_PTR_WAIT,
      S_RD,
      S_RD_WAIT,
      S_UPDATE
   } ft6206_state_t;

endpackage

// File: rtl/i2c_types.sv
// Shared I2C master request types.
package i2c_types;

   typedef enum logic [1:0] {
      READ_8BIT           = 2'd0,
      WRITE_8BIT          = 2'd1,
      WRITE_8BIT_REGISTER = 2'd2
   } i2c_transaction_t;

endpackage

// File: rtl/poll_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module poll_timer #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // load wins over clear, clear wins over decrement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (clear)
         count <= '0;
      else if (dec && count != '0)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ft6206_controller.sv
// FT6206 capacitive touch poller: one threshold write at init, then
// periodic TD_STATUS pointer write followed by five single-byte reads.
`ifndef FT6206_ADDRESS
// keeps this file compilable when the defines file is not read first
`define FT6206_ADDRESS 7'h38
`endif

module ft6206_controller
   import i2c_types::*;
   import ft6206_defines::*;
#(
   parameter int         POLL_CYCLES = 1_000_000,
   parameter logic [7:0] THRESHOLD   = 8'h80
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   output i2c_transaction_t i2c_mode,
   output logic [6:0]       i2c_addr,
   output logic [15:0]      i2c_wr_data,
   output logic             i2c_valid,
   input  logic             i2c_ready,
   input  logic             i2c_rd_valid,
   input  logic [7:0]       i2c_rd_data,
   input  logic             i2c_error,
   output logic [11:0]      touch_x,
   output logic [11:0]      touch_y,
   output logic [1:0]       touch_count,
   output logic             touch_valid,
   output logic             err
);

   localparam int            TW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam logic [TW-1:0] POLL_LOAD = TW'(POLL_CYCLES - 1);

   ft6206_state_t   state;
   logic [4:0][7:0] rd_buf;
   logic [4:0][7:0] buf_next;
   logic [2:0]      idx;
   logic            init_done;
   logic            tmr_zero;

   assign i2c_addr = `FT6206_ADDRESS;

   // Timer is held at its reload value outside S_IDLE so it starts fresh
   // on every idle entry; with polling disabled it parks at zero so a
   // re-enable starts a poll straight away.
   poll_timer #(.W(TW)) u_poll_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (state != S_IDLE),
      .clear    (state == S_IDLE && init_done && !ena),
      .dec      (state == S_IDLE),
      .load_val (POLL_LOAD),
      .zero     (tmr_zero)
   );

   // buffer as it will look once the incoming byte lands; lets the final
   // byte feed the touch outputs in the same cycle it arrives
   always_comb begin
      buf_next      = rd_buf;
      buf_next[idx] = i2c_rd_data;
   end

   // main sequencer with registered request and touch outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_INIT;
         idx         <= '0;
         rd_buf      <= '0;
         init_done   <= 1'b0;
         i2c_valid   <= 1'b0;
         i2c_mode    <= READ_8BIT;
         i2c_wr_data <= '0;
         touch_valid <= 1'b0;
         err         <= 1'b0;
         touch_x     <= '0;
         touch_y     <= '0;
         touch_count <= '0;
      end else begin
         touch_valid <= 1'b0;
         err         <= 1'b0;
         // an error wins over any completion strobe in the same cycle
         if (i2c_error && state != S_IDLE) begin
            state     <= S_IDLE;
            i2c_valid <= 1'b0;
            err       <= 1'b1;
         end else begin
            case (state)
               S_INIT: begin
                  if (!i2c_valid) begin
                     i2c_valid   <= 1'b1;
                     i2c_mode    <= WRITE_8BIT_REGISTER;
                     i2c_wr_data <= {FT6206_REG_TH_GROUP, THRESHOLD};
                  end else if (i2c_ready) begin
                     i2c_valid <= 1'b0;
                     state     <= S_INIT_WAIT;
                  end
               end
               S_INIT_WAIT: begin
                  if (i2c_rd_valid) begin
                     init_done <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
               S_IDLE: begin
                  if (tmr_zero) begin
                     // a failed init is retried instead of polling
                     if (!init_done) begin
                        state       <= S_INIT;
                        i2c_valid   <= 1'b1;
                        i2c_mode    <= WRITE_8BIT_REGISTER;
                        i2c_wr_data <= {FT6206_REG_TH_GROUP, THRESHOLD};
                     end else if (ena) begin
                        state       <= S_PTR;
                        i2c_valid   <= 1'b1;
                        i2c_mode    <= WRITE_8BIT;
                        i2c_wr_data <= {8'h00, FT6206_REG_TD_STATUS};
                     end
                  end
               end
               S_PTR: begin
                  if (i2c_ready) begin
                     i2c_valid <= 1'b0;
                     state     <= S_PTR_WAIT;
                  end
               end
               S_PTR_WAIT: begin
                  if (i2c_rd_valid) begin
                     idx         <= '0;
                     state       <= S_RD;
                     i2c_valid   <= 1'b1;
                     i2c_mode    <= READ_8BIT;
                     i2c_wr_data <= '0;
                  end
               end
               S_RD: begin
                  if (i2c_ready) begin
                     i2c_valid <= 1'b0;
                     state     <= S_RD_WAIT;
                  end
               end
               S_RD_WAIT: begin
                  if (i2c_rd_valid) begin
                     rd_buf <= buf_next;
                     if (idx < 3'd4) begin
                        idx       <= idx + 3'd1;
                        state     <= S_RD;
                        i2c_valid <= 1'b1;
                     end else begin
                        touch_x     <= {buf_next[1][3:0], buf_next[2]};
                        touch_y     <= {buf_next[3][3:0], buf_next[4]};
                        // more than two touches is not a valid report
                        touch_count <= (buf_next[0][3:0] <= 4'd2) ? buf_next[0][1:0] : 2'd0;
                        touch_valid <= 1'b1;
                        state       <= S_UPDATE;
                     end
                  end
               end
               S_UPDATE: state <= S_IDLE;
               default:  state <= S_INIT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ft6206_controller.sv
// Bench: acts as the I2C master with random handshake timing, predicts
// request timing and touch reports from the poller's rules.
module tb_ft6206_controller;
   import i2c_types::*;

   localparam int P        = 10;
   localparam int WAIT_MAX = 4 * P + 40;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ena = 1'b0;
   logic             i2c_ready = 1'b0;
   logic             i2c_rd_valid = 1'b0;
   logic             i2c_error = 1'b0;
   logic [7:0]       i2c_rd_data = '0;
   i2c_transaction_t i2c_mode;
   logic [6:0]       i2c_addr;
   logic [15:0]      i2c_wr_data;
   logic             i2c_valid;
   logic [11:0]      touch_x, touch_y;
   logic [1:0]       touch_count;
   logic             touch_valid, err;

   ft6206_controller #(.POLL_CYCLES(P), .THRESHOLD(8'h80)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .i2c_mode(i2c_mode), .i2c_addr(i2c_addr), .i2c_wr_data(i2c_wr_data),
      .i2c_valid(i2c_valid), .i2c_ready(i2c_ready),
      .i2c_rd_valid(i2c_rd_valid), .i2c_rd_data(i2c_rd_data), .i2c_error(i2c_error),
      .touch_x(touch_x), .touch_y(touch_y), .touch_count(touch_count),
      .touch_valid(touch_valid), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_vec = 0, n_bad = 0;
   // reported touch state, and the report pending for exp_tv_cyc
   logic [11:0] mx = '0, my = '0, px = '0, py = '0;
   logic [1:0]  mc = '0, pc = '0;
   int          exp_tv_cyc = -1, exp_err_cyc = -1, next_start = -1, rdy_force = -1;
   logic [7:0]  pb [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic model_reset();
      mx = '0; my = '0; mc = '0;
      exp_tv_cyc = -1; exp_err_cyc = -1;
   endtask

   // per-cycle comparison of pulses and held touch outputs
   always @(negedge clk) begin
      if (cyc == exp_tv_cyc) begin
         mx = px; my = py; mc = pc;
      end
      chk("touch_valid", 32'(touch_valid), 32'(cyc == exp_tv_cyc));
      chk("err",         32'(err),         32'(cyc == exp_err_cyc));
      chk("touch_x",     32'(touch_x),     32'(mx));
      chk("touch_y",     32'(touch_y),     32'(my));
      chk("touch_count", 32'(touch_count), 32'(mc));
      chk("i2c_addr",    32'(i2c_addr),    32'h38);
   end

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic wait_valid(output int s);
      int n = 0;
      while (!i2c_valid && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (!i2c_valid) begin
         n_vec++; n_bad++;
         $display("FAIL req_wait: no request within %0d cycles (cycle %0d)", WAIT_MAX, cyc);
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
         $fatal(1, "request timeout");
      end
      s = cyc;
   endtask

   // serve one request; err_mode 0 none, 1 error while request pending,
   // 2 error on the completion strobe
   task automatic xact(input i2c_transaction_t m, input logic [15:0] d, input bit chk_d,
                       input int err_mode, input logic [7:0] rb,
                       output bit ok, output int sc);
      int s, rd, rs;
      wait_valid(s);
      if (next_start >= 0) chk("req_start", 32'(s), 32'(next_start));
      chk("req_mode", 32'(i2c_mode), 32'(m));
      if (chk_d) chk("req_data", 32'(i2c_wr_data), 32'(d));
      if (err_mode == 1) begin
         exp_err_cyc = s + 1;
         next_start  = s + 1 + P;
         i2c_error = 1'b1;
         @(negedge clk);
         i2c_error = 1'b0;
         chk("abort_valid", 32'(i2c_valid), 32'd0);
         ok = 1'b0; sc = s;
         return;
      end
      rd = (rdy_force >= 0) ? rdy_force : int'($urandom_range(0, 5));
      repeat (rd) begin
         @(negedge clk);
         chk("hold_valid", 32'(i2c_valid), 32'd1);
         chk("hold_mode",  32'(i2c_mode),  32'(m));
         if (chk_d) chk("hold_data", 32'(i2c_wr_data), 32'(d));
      end
      i2c_ready = 1'b1;
      @(negedge clk);
      i2c_ready = 1'b0;
      chk("valid_drop", 32'(i2c_valid), 32'd0);
      rs = int'($urandom_range(0, 3));
      repeat (rs) begin
         // stray ready while no request is pending must be ignored
         i2c_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         i2c_ready = 1'b0;
         chk("valid_idle", 32'(i2c_valid), 32'd0);
      end
      sc = cyc;
      i2c_rd_data = rb;
      if (err_mode == 2) begin
         i2c_error    = 1'b1;
         i2c_rd_valid = 1'($urandom_range(0, 1));
         exp_err_cyc  = cyc + 1;
         next_start   = cyc + 1 + P;
         ok = 1'b0;
      end else begin
         i2c_rd_valid = 1'b1;
         next_start   = cyc + 1;
         ok = 1'b1;
      end
      @(negedge clk);
      i2c_rd_valid = 1'b0;
      i2c_error    = 1'b0;
   endtask

   task automatic do_init(input int err_mode);
      bit ok; int c;
      xact(WRITE_8BIT_REGISTER, 16'h8080, 1'b1, err_mode, 8'h00, ok, c);
      if (ok) next_start = c + 1 + P;
   endtask

   // one poll of the bytes in pb; err_t picks the failing transfer
   // (0 pointer write, 1..5 reads), drop_t the read before which ena drops
   task automatic do_poll(input int err_t, input int err_mode, input int drop_t);
      bit ok; int c;
      xact(WRITE_8BIT, 16'h0002, 1'b1, (err_t == 0) ? err_mode : 0, 8'h00, ok, c);
      if (!ok) return;
      for (int t = 1; t <= 5; t++) begin
         if (drop_t == t) ena = 1'b0;
         xact(READ_8BIT, 16'h0000, 1'b0, (err_t == t) ? err_mode : 0, pb[t-1], ok, c);
         if (!ok) return;
      end
      px = {pb[1][3:0], pb[2]};
      py = {pb[3][3:0], pb[4]};
      pc = (pb[0][3:0] <= 4'd2) ? pb[0][1:0] : 2'd0;
      exp_tv_cyc = c + 1;
      next_start = c + 2 + P;
   endtask

   task automatic rand_bytes();
      for (int i = 0; i < 5; i++) pb[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) pb[0] = pb[0] & 8'hF3;
   endtask

   task automatic lit(input logic [11:0] x, input logic [11:0] y, input logic [1:0] n);
      chk("lit_touch_x", 32'(touch_x), 32'(x));
      chk("lit_touch_y", 32'(touch_y), 32'(y));
      chk("lit_touch_count", 32'(touch_count), 32'(n));
   endtask

   initial begin
      bit ok;
      int c, s, et, em;
      #1 rst = 1'b0;
      ena = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_i2c_valid", 32'(i2c_valid), 32'd0);
      lit(12'h000, 12'h000, 2'd0);

      // init write appears on the first cycle after release, held 5 cycles
      next_start = cyc + 1;
      rst = 1'b1;
      rdy_force = 5;
      do_init(0);
      rdy_force = -1;

      pb = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4};
      do_poll(-1, 0, -1);
      chk("lit_touch_valid", 32'(touch_valid), 32'd1);
      lit(12'h1F2, 12'h3F4, 2'd0);

      pb = '{8'h02, 8'h81, 8'h23, 8'h05, 8'h67};
      do_poll(-1, 0, -1);
      lit(12'h123, 12'h567, 2'd2);

      pb = '{8'h0F, 8'h81, 8'h23, 8'h05, 8'h67};
      do_poll(-1, 0, -1);
      lit(12'h123, 12'h567, 2'd0);

      // error on the third read leaves the last report untouched
      pb = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_poll(3, 2, -1);
      chk("lit_err", 32'(err), 32'd1);
      lit(12'h123, 12'h567, 2'd0);

      pb = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      do_poll(-1, 0, -1);
      lit(12'h234, 12'h678, 2'd1);

      for (int k = 0; k < 30; k++) begin
         rand_bytes();
         et = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
         em = int'($urandom_range(1, 2));
         do_poll(et, em, -1);
      end

      // ena dropped mid-read: that poll finishes, no new one starts
      rand_bytes();
      do_poll(-1, 0, 2);
      repeat (4 * P) begin
         @(negedge clk);
         chk("ena_low_quiet", 32'(i2c_valid), 32'd0);
      end
      next_start = cyc + 1;
      ena = 1'b1;
      rand_bytes();
      do_poll(-1, 0, -1);

      // reset while a read request is pending
      xact(WRITE_8BIT, 16'h0002, 1'b1, 0, 8'h00, ok, c);
      wait_valid(s);
      chk("rd_after_ptr", 32'(s), 32'(c + 1));
      #2;
      model_reset();
      rst = 1'b0;
      #1;
      chk("rst_drop_valid", 32'(i2c_valid), 32'd0);
      repeat (2) @(negedge clk);
      next_start = cyc + 1;
      rst = 1'b1;
      // failed init is retried after the poll interval, then polling resumes
      do_init(2);
      do_init(0);
      rand_bytes();
      do_poll(-1, 0, -1);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
